// File: rtl/mem_arbiter.sv
// Byte-serial arbiter for the 8-bit RAM/IO port. Store commit has priority over loads,
// and loads over instruction fetch. Read bytes are reassembled and load results are extended.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  rollback,
  input  logic                  io_buffer_full,
  input  logic                  st_req,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [1:0]            st_size,
  input  logic [DATA_WIDTH-1:0] st_data,
  output logic                  st_done,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [1:0]            ld_size,
  input  logic                  ld_signed,
  output logic                  ld_done,
  output logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_data,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [1:0] SRC_ST = 2'd0;
  localparam logic [1:0] SRC_LD = 2'd1;
  localparam logic [1:0] SRC_IF = 2'd2;

  state_t                r_state, w_next;
  logic [1:0]            r_src;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [2:0]            r_cnt, r_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data, r_buf;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [7:0]            r_mem_dout;
  logic                  r_mem_wr, r_st_done, r_ld_done, r_if_done;
  logic [DATA_WIDTH-1:0] r_ld_data, r_if_data;

  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [1:0]            w_req_size;
  logic [1:0]            w_req_src;
  logic                  w_grant, w_st_stall, w_wr_stall;
  logic [1:0]            w_idx;
  logic [DATA_WIDTH-1:0] w_word;

  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      2'd0:    size_len = 3'd1;
      2'd1:    size_len = 3'd2;
      default: size_len = 3'd4;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [1:0] size, input logic sgn);
    logic signed [7:0]            v_b;
    logic signed [15:0]           v_h;
    logic signed [DATA_WIDTH-1:0] v_s;
    v_b = word[7:0];
    v_h = word[15:0];
    case (size)
      2'd0: begin
        v_s = DATA_WIDTH'(v_b);
        extend_load = sgn ? v_s : {{(DATA_WIDTH-8){1'b0}}, word[7:0]};
      end
      2'd1: begin
        v_s = DATA_WIDTH'(v_h);
        extend_load = sgn ? v_s : {{(DATA_WIDTH-16){1'b0}}, word[15:0]};
      end
      default: extend_load = word;
    endcase
  endfunction

  always_comb begin
    w_req_addr = if_addr;
    w_req_size = 2'd2;
    w_req_src  = SRC_IF;
    if (st_req) begin
      w_req_addr = st_addr;
      w_req_size = st_size;
      w_req_src  = SRC_ST;
    end else if (ld_req) begin
      w_req_addr = ld_addr;
      w_req_size = ld_size;
      w_req_src  = SRC_LD;
    end
  end

  assign w_grant    = (st_req | ld_req | if_req) & ~rollback;
  assign w_st_stall = (st_addr[17:16] == 2'b11) & io_buffer_full;
  assign w_wr_stall = (r_addr[17:16] == 2'b11) & io_buffer_full;

  // The byte arriving on mem_din belongs to the address driven two edges earlier.
  always_comb begin
    w_idx  = r_cnt[1:0] - 2'd1;
    w_word = r_buf;
    w_word[{w_idx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next = st_req ? WRITE : READ;
      READ:    if (rollback) w_next = IDLE;
               else if (r_cnt == r_len) w_next = DONE;
      WRITE:   if (r_cnt == r_len) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)      r_state <= IDLE;
    else if (rdy) r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (r_state == IDLE && w_grant) begin
        r_src    <= w_req_src;
        r_addr   <= w_req_addr;
        r_size   <= w_req_size;
        r_signed <= ld_signed;
        r_data   <= st_data;
        r_buf    <= '0;
      end else if (r_state == READ && r_cnt != 3'd0) begin
        r_buf <= w_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 3'd0;
      r_len      <= 3'd0;
      r_mem_a    <= '0;
      r_mem_dout <= 8'd0;
      r_mem_wr   <= 1'b0;
      r_st_done  <= 1'b0;
      r_ld_done  <= 1'b0;
      r_if_done  <= 1'b0;
      r_ld_data  <= '0;
      r_if_data  <= '0;
    end else if (!rdy) begin
      r_mem_wr <= 1'b0;
    end else begin
      r_st_done <= 1'b0;
      r_ld_done <= 1'b0;
      r_if_done <= 1'b0;
      r_mem_wr  <= 1'b0;
      case (r_state)
        IDLE: if (w_grant) begin
          r_len   <= size_len(w_req_size);
          r_mem_a <= w_req_addr;
          r_cnt   <= 3'd0;
          // r_cnt counts bytes already issued; a stalled first byte is reissued from WRITE.
          if (st_req) begin
            r_mem_dout <= st_data[7:0];
            if (!w_st_stall) begin
              r_cnt    <= 3'd1;
              r_mem_wr <= 1'b1;
            end
          end
        end
        READ: if (!rollback) begin
          r_cnt   <= r_cnt + 3'd1;
          r_mem_a <= r_mem_a + ADDR_WIDTH'(1);
          if (r_cnt == r_len) begin
            if (r_src == SRC_LD) begin
              r_ld_done <= 1'b1;
              r_ld_data <= extend_load(w_word, r_size, r_signed);
            end else begin
              r_if_done <= 1'b1;
              r_if_data <= w_word;
            end
          end
        end
        WRITE: begin
          if (r_cnt == r_len) begin
            r_st_done <= 1'b1;
          end else if (!w_wr_stall) begin
            r_mem_a    <= r_addr + ADDR_WIDTH'(r_cnt);
            r_mem_dout <= r_data[{r_cnt[1:0], 3'b000} +: 8];
            r_mem_wr   <= 1'b1;
            r_cnt      <= r_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign st_done  = r_st_done;
  assign ld_done  = r_ld_done;
  assign ld_data  = r_ld_data;
  assign if_done  = r_if_done;
  assign if_data  = r_if_data;
  assign mem_dout = r_mem_dout;
  assign mem_a    = r_mem_a;
  assign mem_wr   = r_mem_wr;

endmodule
